// File: rtl/jtcontra_snd_cmdq_if.sv
// Main-CPU / sound-CPU side signals of the sound-command queue.
// JTCONTRA_CMDQ_TIMEOUT_EN adds the sticky tout flag.
interface jtcontra_snd_cmdq_if #(
  parameter int unsigned AW = 3
);
  logic          main_wr;
  logic [7:0]    main_din;
  logic          full;
  logic          ovf;
  logic          ovf_clr;
  logic [AW:0]   level;
  logic [7:0]    snd_latch;
  logic          snd_irq;
  logic          snd_ack;
  logic          busy;
`ifdef JTCONTRA_CMDQ_TIMEOUT_EN
  logic          tout;
`endif

  modport master (
    output main_wr, main_din, ovf_clr, snd_ack,
    input  full, ovf, level, snd_latch, snd_irq, busy
`ifdef JTCONTRA_CMDQ_TIMEOUT_EN
    , input tout
`endif
  );

  modport slave (
    input  main_wr, main_din, ovf_clr, snd_ack,
    output full, ovf, level, snd_latch, snd_irq, busy
`ifdef JTCONTRA_CMDQ_TIMEOUT_EN
    , output tout
`endif
  );
endinterface

// File: rtl/jtcontra_snd_cmdq.sv
// Sound-command FIFO plus latch/IRQ sequencer toward the sound CPU.
// Define JTCONTRA_CMDQ_TIMEOUT_EN to bound the ack wait by TIMEOUT cen pulses.
module jtcontra_snd_cmdq #(
  parameter int unsigned AW      = 3,
  parameter int unsigned IRQ_LEN = 4,
  parameter int unsigned GAP_LEN = 8
`ifdef JTCONTRA_CMDQ_TIMEOUT_EN
  , parameter logic [15:0] TIMEOUT = 16'd3000
`endif
)(
  input  logic               clk,
  input  logic               rstn,
  input  logic               cen,
  jtcontra_snd_cmdq_if.slave bus
);
  localparam int unsigned DEPTH    = 2**AW;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [15:0] IRQ_LAST = 16'(IRQ_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, ASSERT, WAIT, GAP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d, ovf_q, ovf_d;
  logic [7:0]    latch_q, latch_d;
  logic          irq_q, irq_d, busy_q, busy_d;
  logic          ack_seen_q, ack_seen_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          push, pop, drop;
`ifdef JTCONTRA_CMDQ_TIMEOUT_EN
  logic          tout_q, tout_d, expire;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_seen_d = ack_seen_q;
    latch_d    = latch_q;
    pop        = 1'b0;
`ifdef JTCONTRA_CMDQ_TIMEOUT_EN
    expire     = 1'b0;
`endif
    case (state_q)
      IDLE:  if (level_q != '0) state_d = LOAD;
      LOAD: begin
        latch_d = mem[rd_ptr_q];
        pop     = 1'b1;
        state_d = SETUP;
      end
      SETUP: begin
        cnt_d      = '0;
        ack_seen_d = 1'b0;
        state_d    = ASSERT;
      end
      ASSERT: begin
        // an ack arriving while the IRQ is still high must not be lost
        if (bus.snd_ack) ack_seen_d = 1'b1;
        if (cen) begin
          if (cnt_q == IRQ_LAST) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      WAIT: begin
        if (bus.snd_ack || ack_seen_q) begin
          state_d = GAP;
          cnt_d   = '0;
        end
`ifdef JTCONTRA_CMDQ_TIMEOUT_EN
        else if (cen) begin
          if (cnt_q == TIMEOUT - 16'd1) begin
            state_d = GAP;
            cnt_d   = '0;
            expire  = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
`endif
      end
      GAP: begin
        if (GAP_LEN == 0) begin
          state_d = IDLE;
        end else if (cen) begin
          if (cnt_q == GAP_LAST) state_d = IDLE;
          else                   cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a full FIFO still accepts a write in the clk it is being popped
  always_comb begin
    push     = bus.main_wr && (!full_q || pop);
    drop     = bus.main_wr && !push;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
    full_d   = (level_d == FULL_LVL);
    ovf_d    = drop || (ovf_q && !bus.ovf_clr);
    irq_d    = (state_d == ASSERT);
    busy_d   = (state_d != IDLE);
`ifdef JTCONTRA_CMDQ_TIMEOUT_EN
    tout_d   = expire || (tout_q && !bus.ovf_clr);
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.main_din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      latch_q    <= '0;
      irq_q      <= 1'b0;
      busy_q     <= 1'b0;
      ack_seen_q <= 1'b0;
      cnt_q      <= '0;
`ifdef JTCONTRA_CMDQ_TIMEOUT_EN
      tout_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      latch_q    <= latch_d;
      irq_q      <= irq_d;
      busy_q     <= busy_d;
      ack_seen_q <= ack_seen_d;
      cnt_q      <= cnt_d;
`ifdef JTCONTRA_CMDQ_TIMEOUT_EN
      tout_q     <= tout_d;
`endif
    end
  end

  assign bus.level     = level_q;
  assign bus.full      = full_q;
  assign bus.ovf       = ovf_q;
  assign bus.snd_latch = latch_q;
  assign bus.snd_irq   = irq_q;
  assign bus.busy      = busy_q;
`ifdef JTCONTRA_CMDQ_TIMEOUT_EN
  assign bus.tout      = tout_q;
`endif
endmodule
